// File: rtl/nbcac_pkg.sv
// Shared NBCAC widths, stage records and the 6->8 codeword table.
// Codewords are the 64 lowest 8-bit values that contain no 010/101 bit pattern.
package nbcac_pkg;
  localparam int NBCAC_DATA_W = 6;
  localparam int NBCAC_CODE_W = 8;
  localparam logic [NBCAC_CODE_W-1:0] NBCAC_IDLE_CODE = 8'h00;

  localparam logic [NBCAC_CODE_W-1:0] NBCAC_ENC_LUT [0:63] = '{
    8'h00, 8'h01, 8'h03, 8'h06, 8'h07, 8'h0C, 8'h0E, 8'h0F,
    8'h18, 8'h19, 8'h1C, 8'h1E, 8'h1F, 8'h30, 8'h31, 8'h33,
    8'h38, 8'h39, 8'h3C, 8'h3E, 8'h3F, 8'h60, 8'h61, 8'h63,
    8'h66, 8'h67, 8'h70, 8'h71, 8'h73, 8'h78, 8'h79, 8'h7C,
    8'h7E, 8'h7F, 8'h80, 8'h81, 8'h83, 8'h86, 8'h87, 8'h8C,
    8'h8E, 8'h8F, 8'h98, 8'h99, 8'h9C, 8'h9E, 8'h9F, 8'hC0,
    8'hC1, 8'hC3, 8'hC6, 8'hC7, 8'hCC, 8'hCE, 8'hCF, 8'hE0,
    8'hE1, 8'hE3, 8'hE6, 8'hE7, 8'hF0, 8'hF1, 8'hF3, 8'hF8
  };

  typedef struct packed {
    logic                    vld;
    logic [NBCAC_DATA_W-1:0] data;
  } s1_t;

  typedef struct packed {
    logic                    vld;
    logic [NBCAC_CODE_W-1:0] code;
  } s2_t;
endpackage

// File: rtl/nbcac_6di_decoder_core.sv
// Combinational inverse of the NBCAC table; codes outside the table decode to 0.
module nbcac_6di_decoder_core
  import nbcac_pkg::*;
(
  input  logic [NBCAC_CODE_W-1:0] i_d,
  output logic [NBCAC_DATA_W-1:0] o_v
);
  always_comb begin
    o_v = '0;
    for (int i = 0; i < 64; i++)
      if (NBCAC_ENC_LUT[i] == i_d) o_v = NBCAC_DATA_W'(i);
  end
endmodule

// File: rtl/nbcac_6di_encoder_core.sv
// Combinational 6-bit data to 8-bit NBCAC codeword map.
module nbcac_6di_encoder_core
  import nbcac_pkg::*;
(
  input  logic [NBCAC_DATA_W-1:0] i_v,
  output logic [NBCAC_CODE_W-1:0] o_d
);
  assign o_d = NBCAC_ENC_LUT[i_v];
endmodule

// File: rtl/nbcac_encoder_8.sv
// NBCAC transmit encoder: input reg S1, code reg S2, registered link output.
// NBCAC_ENC_CHECK_EN adds a decode-and-compare self check driving chk_err.
module nbcac_encoder_8
  import nbcac_pkg::*;
#(
  parameter logic [NBCAC_CODE_W-1:0] IDLE_CODE = NBCAC_IDLE_CODE,
  parameter int                      CNT_W     = 16
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic [NBCAC_DATA_W-1:0] datain,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NBCAC_CODE_W-1:0] codeout,
  output logic                    code_valid,
  input  logic                    link_ready,
  output logic [CNT_W-1:0]        sent_cnt,
  output logic                    chk_err
);
  s1_t                     r_s1;
  s2_t                     r_s2;
  logic [NBCAC_CODE_W-1:0] r_code;
  logic                    r_code_valid;
  logic [CNT_W-1:0]        r_cnt;
  logic                    w_send, w_adv, w_acc;
  logic [NBCAC_CODE_W-1:0] w_enc;

  nbcac_6di_encoder_core u_enc (.i_v(r_s1.data), .o_d(w_enc));

  assign w_send   = r_s2.vld & link_ready;
  assign w_adv    = r_s1.vld & (~r_s2.vld | w_send);
  assign in_ready = ~r_s1.vld | w_adv;
  assign w_acc    = in_valid & in_ready;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_s1         <= '0;
      r_s2         <= '0;
      r_code       <= IDLE_CODE;
      r_code_valid <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_s1.vld <= w_acc | (r_s1.vld & ~w_adv);
      if (w_acc) r_s1.data <= datain;
      r_s2.vld <= w_adv | (r_s2.vld & ~w_send);
      if (w_adv) r_s2.code <= w_enc;
      // codeout only moves on a send, so an idle link keeps its last codeword
      r_code_valid <= w_send;
      if (w_send) begin
        r_code <= r_s2.code;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign codeout    = r_code;
  assign code_valid = r_code_valid;
  assign sent_cnt   = r_cnt;

`ifdef NBCAC_ENC_CHECK_EN
  logic [NBCAC_DATA_W-1:0] r_s2_data;
  logic [NBCAC_DATA_W-1:0] w_chk_dec;
  logic                    r_chk_err;

  // decode the code that is about to be driven and compare with its source word
  nbcac_6di_decoder_core u_chk_dec (.i_d(r_s2.code), .o_v(w_chk_dec));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_data <= '0;
      r_chk_err <= 1'b0;
    end else begin
      if (w_adv) r_s2_data <= r_s1.data;
      if (w_send && (w_chk_dec != r_s2_data)) r_chk_err <= 1'b1;
    end
  end

  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif
endmodule
